// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit.
// Contains cpu_types_pkg (ALU opcode and FSM state types) followed by the
// sequencing FSM FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
// Cache handshakes: a request line (iREN, dREN or dWEN) is held high while
// the FSM sits in FETCH or MEM; the matching hit (ihit or dhit) completes the
// request in the cycle it is seen high, and is ignored in every other state.
// Optional feature: define MCU_PERF_COUNT_EN to add instr_cnt / cycle_cnt.

package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } mcu_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

module multicycle_control_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] instruction,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              alu_zf,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              IRWr,
    output logic              PCWr,
    output logic [1:0]        PCSrc,
    output logic              RegWr,
    output logic [1:0]        RegDst,
    output logic [1:0]        MemToReg,
    output logic              ALUSrc,
    output logic              ExtOp,
    output aluop_t            ALUctr,
    output logic              halt,
    output logic              timeout,
`ifdef MCU_PERF_COUNT_EN
    output logic [31:0]       instr_cnt,
    output logic [31:0]       cycle_cnt,
`endif
    output mcu_state_t        state_dbg
);

    // Last stall count before the wait limit trips (WAIT_MAX stall cycles total).
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    mcu_state_t       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             halt_q, halt_d;
    logic             timeout_q, timeout_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;

    assign opcode            = instruction[WORD_W-1 -: 6];
    assign funct             = instruction[5:0];
    assign unused_instr_bits = ^instruction[WORD_W-7:6];

    // Instruction class decode
    aluop_t dec_alu;
    logic   dec_src, dec_ext, dec_rtype;
    logic   dec_lw, dec_sw, dec_beq, dec_bne;
    logic   dec_j, dec_jal, dec_jr, dec_wb, dec_lui, dec_halt;

    // Classify the instruction; anything unrecognised leaves every class flag low (NOP).
    always_comb begin
        dec_alu   = ALU_SLL;
        dec_src   = 1'b0;
        dec_ext   = 1'b0;
        dec_rtype = 1'b0;
        dec_lw    = 1'b0;
        dec_sw    = 1'b0;
        dec_beq   = 1'b0;
        dec_bne   = 1'b0;
        dec_j     = 1'b0;
        dec_jal   = 1'b0;
        dec_jr    = 1'b0;
        dec_wb    = 1'b0;
        dec_lui   = 1'b0;
        dec_halt  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_rtype = 1'b1;
                dec_wb    = 1'b1;
                case (funct)
                    FN_SLL:          dec_alu = ALU_SLL;
                    FN_SRL:          dec_alu = ALU_SRL;
                    FN_ADD, FN_ADDU: dec_alu = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_alu = ALU_SUB;
                    FN_AND:          dec_alu = ALU_AND;
                    FN_OR:           dec_alu = ALU_OR;
                    FN_XOR:          dec_alu = ALU_XOR;
                    FN_NOR:          dec_alu = ALU_NOR;
                    FN_SLT:          dec_alu = ALU_SLT;
                    FN_SLTU:         dec_alu = ALU_SLTU;
                    FN_JR: begin
                        dec_jr = 1'b1;
                        dec_wb = 1'b0;
                    end
                    default:         dec_wb = 1'b0;
                endcase
            end
            OP_J:   dec_j   = 1'b1;
            OP_JAL: dec_jal = 1'b1;
            OP_BEQ: begin
                dec_beq = 1'b1;
                dec_alu = ALU_SUB;
                dec_ext = 1'b1;
            end
            OP_BNE: begin
                dec_bne = 1'b1;
                dec_alu = ALU_SUB;
                dec_ext = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                dec_alu = ALU_ADD;
                dec_src = 1'b1;
                dec_ext = 1'b1;
                dec_wb  = 1'b1;
            end
            OP_SLTI: begin
                dec_alu = ALU_SLT;
                dec_src = 1'b1;
                dec_ext = 1'b1;
                dec_wb  = 1'b1;
            end
            OP_SLTIU: begin
                dec_alu = ALU_SLTU;
                dec_src = 1'b1;
                dec_ext = 1'b1;
                dec_wb  = 1'b1;
            end
            OP_ANDI: begin
                dec_alu = ALU_AND;
                dec_src = 1'b1;
                dec_wb  = 1'b1;
            end
            OP_ORI: begin
                dec_alu = ALU_OR;
                dec_src = 1'b1;
                dec_wb  = 1'b1;
            end
            OP_XORI: begin
                dec_alu = ALU_XOR;
                dec_src = 1'b1;
                dec_wb  = 1'b1;
            end
            OP_LUI: begin
                dec_lui = 1'b1;
                dec_src = 1'b1;
                dec_wb  = 1'b1;
            end
            OP_LW: begin
                dec_lw  = 1'b1;
                dec_alu = ALU_ADD;
                dec_src = 1'b1;
                dec_ext = 1'b1;
            end
            OP_SW: begin
                dec_sw  = 1'b1;
                dec_alu = ALU_ADD;
                dec_src = 1'b1;
                dec_ext = 1'b1;
            end
            OP_HALT: dec_halt = 1'b1;
            default: ;
        endcase
    end

    // State, wait counter and sticky halt/timeout registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            halt_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            halt_q     <= halt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next state; a hit in the limit cycle completes normally instead of timing out.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        halt_d     = halt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_FETCH: begin
                if (ihit) begin
                    state_d = ST_DECODE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: state_d = dec_halt ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (dec_lw || dec_sw) begin
                    state_d = ST_MEM;
                end else if (dec_wb) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (dhit) begin
                    state_d = dec_lw ? ST_WB : ST_FETCH;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end
        if (state_d == ST_HALT) begin
            halt_d = 1'b1;
        end
    end

    // Output decode from state and instruction; everything forced low while nRST is low.
    always_comb begin
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        PCSrc    = 2'd0;
        RegWr    = 1'b0;
        RegDst   = 2'd0;
        MemToReg = 2'd0;
        ALUSrc   = 1'b0;
        ExtOp    = 1'b0;
        ALUctr   = ALU_SLL;
        if (nRST) begin
            case (state_q)
                ST_FETCH: begin
                    iREN = 1'b1;
                    IRWr = ihit;
                end
                ST_EXEC: begin
                    ALUctr = dec_alu;
                    ALUSrc = dec_src;
                    ExtOp  = dec_ext;
                    if (dec_beq || dec_bne) begin
                        PCWr  = 1'b1;
                        PCSrc = (alu_zf == dec_beq) ? 2'd1 : 2'd0;
                    end else if (dec_j) begin
                        PCWr  = 1'b1;
                        PCSrc = 2'd2;
                    end else if (dec_jal) begin
                        PCWr     = 1'b1;
                        PCSrc    = 2'd2;
                        RegWr    = 1'b1;
                        RegDst   = 2'd2;
                        MemToReg = 2'd2;
                    end else if (dec_jr) begin
                        PCWr  = 1'b1;
                        PCSrc = 2'd3;
                    end else if (!dec_lw && !dec_sw && !dec_wb) begin
                        PCWr = 1'b1;
                    end
                end
                ST_MEM: begin
                    ALUctr = dec_alu;
                    ALUSrc = dec_src;
                    ExtOp  = dec_ext;
                    dREN   = dec_lw;
                    dWEN   = dec_sw;
                    PCWr   = dec_sw && dhit;
                end
                ST_WB: begin
                    ALUctr   = dec_alu;
                    ALUSrc   = dec_src;
                    ExtOp    = dec_ext;
                    RegWr    = 1'b1;
                    PCWr     = 1'b1;
                    RegDst   = dec_rtype ? 2'd1 : 2'd0;
                    MemToReg = dec_lw ? 2'd1 : (dec_lui ? 2'd3 : 2'd0);
                end
                default: ;
            endcase
        end
    end

    assign halt      = halt_q;
    assign timeout   = timeout_q;
    assign state_dbg = state_q;

`ifdef MCU_PERF_COUNT_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    // Performance counters; both freeze once HALT is reached.
    always_comb begin
        instr_cnt_d = instr_cnt_q + {31'd0, PCWr};
        cycle_cnt_d = cycle_cnt_q;
        if (state_q != ST_HALT) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule
